// File: rtl/uart_sys_pkg.sv
// -----------------------------------------------------------------------------
// uart_sys_pkg
// Shared definitions for the UART receive-command path:
//   - command byte codes recognised by rx_cmd_ctrl
//   - register-file addresses that receive the two ALU operands
//   - the command FSM state enum and small decode helpers
// -----------------------------------------------------------------------------
package uart_sys_pkg;

    // Command codes, the first byte of every frame
    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPS = 8'hCC;
    localparam logic [7:0] CMD_ALU_FUN = 8'hDD;

    // Register-file slots that hold the ALU operands
    localparam int unsigned ALU_OPA_ADDR = 32'd0;
    localparam int unsigned ALU_OPB_ADDR = 32'd1;

    // Command FSM states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ADDR  = 3'd1,
        WR_DATA  = 3'd2,
        RD_ADDR  = 3'd3,
        ALU_OPA  = 3'd4,
        ALU_OPB  = 3'd5,
        ALU_FUNC = 3'd6
    } rx_state_e;

    // Maps a command byte to the first state of its frame; IDLE means unknown
    function automatic rx_state_e decode_cmd(input logic [7:0] cmd);
        rx_state_e nxt;
        case (cmd)
            CMD_RF_WR:   nxt = WR_ADDR;
            CMD_RF_RD:   nxt = RD_ADDR;
            CMD_ALU_OPS: nxt = ALU_OPA;
            CMD_ALU_FUN: nxt = ALU_FUNC;
            default:     nxt = IDLE;
        endcase
        return nxt;
    endfunction

    // True for the states belonging to an ALU frame (ALU clock must run)
    function automatic logic is_alu_state(input rx_state_e st);
        return (st == ALU_OPA) || (st == ALU_OPB) || (st == ALU_FUNC);
    endfunction

endpackage

// File: rtl/rx_cmd_ctrl_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Inter-byte gap counter. Counts clock cycles while 'run' is high and flags
// 'expired' once the count reaches TIMEOUT_CYC-1. The count restarts from zero
// on 'clr', whenever 'run' is low, and right after expiry.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   clr      in   restart the gap (a byte was accepted)
//   run      in   a frame is in progress
//   expired  out  gap limit reached this cycle (combinational)
// -----------------------------------------------------------------------------
module frame_timer
    import uart_sys_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 32'd1) ? $clog2(TIMEOUT_CYC) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry only matters while a frame is open
    assign expired = run && (cnt_q == CNT_LIMIT);

    // Next count: restart on clear, idle or expiry, otherwise advance
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !run || expired) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// rx_cmd_ctrl
// Turns the byte stream of a UART receiver into register-file and ALU
// commands. Frames:
//   AA addr data        -> register write
//   BB addr             -> register read
//   CC opA opB fun      -> write opA to RF[0], opB to RF[1], then ALU op
//   DD fun              -> ALU op on the operands already stored
// A byte with a parity/stop error, or a too-long gap inside a frame, aborts
// the frame with a frm_err pulse. Unknown command bytes pulse cmd_err.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   RX_P_DATA/RX_D_VLD        received byte and its valid level
//   RX_PAR_Err/RX_STP_Err     error flags for the current byte
//   RF_WrEn/RF_RdEn           register-file strobes
//   RF_Address/RF_WrData      register-file address / write data (held)
//   ALU_EN/ALU_FUN            ALU strobe and function code (held)
//   ALU_CLK_EN                ALU clock enable for the duration of an ALU frame
//   cmd_err/frm_err           unknown-command and frame-abort pulses
// All outputs are registered; strobes appear the cycle after the byte is taken.
// -----------------------------------------------------------------------------
module rx_cmd_ctrl
    import uart_sys_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_Err,
    input  logic                  RX_STP_Err,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_CLK_EN,
    output logic                  cmd_err,
    output logic                  frm_err
);

    rx_state_e             state_q,   state_d;
    logic                  vld_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_en_q,   wr_en_d;
    logic                  rd_en_q,   rd_en_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  alu_en_q,  alu_en_d;
    logic [3:0]            alu_fun_q, alu_fun_d;
    logic                  clk_en_q,  clk_en_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  frm_err_q, frm_err_d;

    logic      accept_s;
    logic      byte_err_s;
    logic      upper_zero_s;
    rx_state_e cmd_state_s;
    logic      timer_run_s;
    logic      expired_s;

    // A byte is taken only on the rising edge of the valid level
    assign accept_s   = RX_D_VLD && !vld_q;
    assign byte_err_s = RX_PAR_Err || RX_STP_Err;

    // Command codes are 8-bit; wider bytes must carry zeros above bit 7
    assign upper_zero_s = ((RX_P_DATA >> 4'd8) == {DATA_WIDTH{1'b0}});
    assign cmd_state_s  = upper_zero_s ? decode_cmd(RX_P_DATA[7:0]) : IDLE;

    assign timer_run_s = (state_q != IDLE);

    frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept_s),
        .run     (timer_run_s),
        .expired (expired_s)
    );

    // Next state and next output values; an accepted byte outranks a timeout
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        cmd_err_d = 1'b0;
        frm_err_d = 1'b0;
        rf_addr_d = rf_addr_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;

        if (accept_s) begin
            if (byte_err_s) begin
                frm_err_d = 1'b1;
                state_d   = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_state_s == IDLE) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            cmd_err_d = 1'b0;
                        end
                        state_d = cmd_state_s;
                    end
                    WR_ADDR: begin
                        wr_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                        state_d   = WR_DATA;
                    end
                    WR_DATA: begin
                        wr_en_d   = 1'b1;
                        rf_addr_d = wr_addr_q;
                        wr_data_d = RX_P_DATA;
                        state_d   = IDLE;
                    end
                    RD_ADDR: begin
                        rd_en_d   = 1'b1;
                        rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                        state_d   = IDLE;
                    end
                    ALU_OPA: begin
                        wr_en_d   = 1'b1;
                        rf_addr_d = ADDR_WIDTH'(ALU_OPA_ADDR);
                        wr_data_d = RX_P_DATA;
                        state_d   = ALU_OPB;
                    end
                    ALU_OPB: begin
                        wr_en_d   = 1'b1;
                        rf_addr_d = ADDR_WIDTH'(ALU_OPB_ADDR);
                        wr_data_d = RX_P_DATA;
                        state_d   = ALU_FUNC;
                    end
                    ALU_FUNC: begin
                        alu_en_d  = 1'b1;
                        alu_fun_d = RX_P_DATA[3:0];
                        state_d   = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else if (expired_s) begin
            frm_err_d = 1'b1;
            state_d   = IDLE;
        end else begin
            state_d = state_q;
        end

        // ALU clock runs while an ALU frame is open and through the ALU_EN cycle
        clk_en_d = is_alu_state(state_d) || alu_en_d;
    end

    // State, edge detector and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vld_q     <= 1'b0;
            wr_addr_q <= {ADDR_WIDTH{1'b0}};
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rf_addr_q <= {ADDR_WIDTH{1'b0}};
            wr_data_q <= {DATA_WIDTH{1'b0}};
            alu_en_q  <= 1'b0;
            alu_fun_q <= 4'd0;
            clk_en_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_q     <= RX_D_VLD;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            rf_addr_q <= rf_addr_d;
            wr_data_q <= wr_data_d;
            alu_en_q  <= alu_en_d;
            alu_fun_q <= alu_fun_d;
            clk_en_q  <= clk_en_d;
            cmd_err_q <= cmd_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    assign RF_WrEn    = wr_en_q;
    assign RF_RdEn    = rd_en_q;
    assign RF_Address = rf_addr_q;
    assign RF_WrData  = wr_data_q;
    assign ALU_EN     = alu_en_q;
    assign ALU_FUN    = alu_fun_q;
    assign ALU_CLK_EN = clk_en_q;
    assign cmd_err    = cmd_err_q;
    assign frm_err    = frm_err_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_cmd_ctrl
// Self-checking bench for rx_cmd_ctrl: a table of byte vectors with expected
// outputs, directed multi-cycle sequences (held valid, timeout, byte at the
// timeout boundary, reset mid-frame) and random traffic. A frame-level
// reference model (queue of bytes of the open frame) is compared every cycle.
// Output vector layout: {WrEn,RdEn,ALU_EN,cmd_err,frm_err,ALU_CLK_EN,
//                        RF_Address[3:0], RF_WrData[7:0], ALU_FUN[3:0]}
// -----------------------------------------------------------------------------
module tb_rx_cmd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rx_data;
    logic          rx_vld;
    logic          rx_par;
    logic          rx_stp;
    logic          rf_wren, rf_rden, alu_en, alu_clk_en, cmd_err, frm_err;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [3:0]    alu_fun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_cmd_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_P_DATA  (rx_data),
        .RX_D_VLD   (rx_vld),
        .RX_PAR_Err (rx_par),
        .RX_STP_Err (rx_stp),
        .RF_WrEn    (rf_wren),
        .RF_RdEn    (rf_rden),
        .RF_Address (rf_addr),
        .RF_WrData  (rf_wdata),
        .ALU_EN     (alu_en),
        .ALU_FUN    (alu_fun),
        .ALU_CLK_EN (alu_clk_en),
        .cmd_err    (cmd_err),
        .frm_err    (frm_err)
    );

    logic [21:0] act;
    assign act = {rf_wren, rf_rden, alu_en, cmd_err, frm_err, alu_clk_en,
                  rf_addr, rf_wdata, alu_fun};

    // ---------------- reference model (frame level) ----------------
    logic [7:0] frame_q[$];
    int         since;
    logic       m_prev;
    logic [3:0] m_addr;
    logic [7:0] m_wd;
    logic [3:0] m_fun;
    logic       m_wr, m_rd, m_alu, m_cmd, m_frm, m_ce;
    logic [21:0] m_exp = 22'd0;
    logic [21:0] snap;

    task automatic model_tick();
        logic       acc;
        logic [7:0] b0, b1, b2, b3;
        m_wr = 1'b0; m_rd = 1'b0; m_alu = 1'b0; m_cmd = 1'b0; m_frm = 1'b0;
        if (rst) begin
            frame_q.delete();
            since = 0; m_prev = 1'b0;
            m_addr = 4'd0; m_wd = 8'd0; m_fun = 4'd0;
        end else begin
            acc    = rx_vld && !m_prev;
            m_prev = rx_vld;
            if (acc) begin
                since = 0;
                if (rx_par || rx_stp) begin
                    m_frm = 1'b1;
                    frame_q.delete();
                end else if (frame_q.size() == 0) begin
                    if (rx_data == 8'hAA || rx_data == 8'hBB ||
                        rx_data == 8'hCC || rx_data == 8'hDD)
                        frame_q.push_back(rx_data);
                    else
                        m_cmd = 1'b1;
                end else begin
                    frame_q.push_back(rx_data);
                    b0 = frame_q[0];
                    b1 = frame_q[1];
                    b2 = (frame_q.size() > 2) ? frame_q[2] : 8'd0;
                    b3 = (frame_q.size() > 3) ? frame_q[3] : 8'd0;
                    if (b0 == 8'hAA && frame_q.size() == 3) begin
                        m_wr = 1'b1; m_addr = b1[3:0]; m_wd = b2; frame_q.delete();
                    end else if (b0 == 8'hBB) begin
                        m_rd = 1'b1; m_addr = b1[3:0]; frame_q.delete();
                    end else if (b0 == 8'hCC && frame_q.size() == 2) begin
                        m_wr = 1'b1; m_addr = 4'd0; m_wd = b1;
                    end else if (b0 == 8'hCC && frame_q.size() == 3) begin
                        m_wr = 1'b1; m_addr = 4'd1; m_wd = b2;
                    end else if (b0 == 8'hCC && frame_q.size() == 4) begin
                        m_alu = 1'b1; m_fun = b3[3:0]; frame_q.delete();
                    end else if (b0 == 8'hDD) begin
                        m_alu = 1'b1; m_fun = b1[3:0]; frame_q.delete();
                    end
                end
            end else if (frame_q.size() != 0) begin
                since++;
                if (since == TO) begin
                    m_frm = 1'b1;
                    frame_q.delete();
                end
            end
        end
        m_ce = m_alu || (frame_q.size() != 0 &&
                         (frame_q[0] == 8'hCC || frame_q[0] == 8'hDD));
        m_exp = {m_wr, m_rd, m_alu, m_cmd, m_frm, m_ce, m_addr, m_wd, m_fun};
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: advance model with present inputs, let DUT clock, compare
    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
        check_val("model", {10'd0, act}, {10'd0, m_exp});
    endtask

    // Present one byte for one cycle, snapshot outputs, then drop valid
    task automatic send(input logic [7:0] d, input logic p, input logic s);
        rx_data = d; rx_par = p; rx_stp = s; rx_vld = 1'b1;
        tick();
        snap = act;
        rx_vld = 1'b0; rx_par = 1'b0; rx_stp = 1'b0;
        tick();
    endtask

    function automatic logic [21:0] ev(input logic [5:0] s, input logic [3:0] a,
                                       input logic [7:0] w, input logic [3:0] f);
        return {s, a, w, f};
    endfunction

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic        stp;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int seen;
        int cnt;
        logic any_frm;

        tbl[0]  = '{8'hAA, 1'b0, 1'b0, ev(6'b000000, 4'h0, 8'h00, 4'h0)};
        tbl[1]  = '{8'h05, 1'b0, 1'b0, ev(6'b000000, 4'h0, 8'h00, 4'h0)};
        tbl[2]  = '{8'h3C, 1'b0, 1'b0, ev(6'b100000, 4'h5, 8'h3C, 4'h0)};
        tbl[3]  = '{8'hBB, 1'b0, 1'b0, ev(6'b000000, 4'h5, 8'h3C, 4'h0)};
        tbl[4]  = '{8'h0A, 1'b0, 1'b0, ev(6'b010000, 4'hA, 8'h3C, 4'h0)};
        tbl[5]  = '{8'hCC, 1'b0, 1'b0, ev(6'b000001, 4'hA, 8'h3C, 4'h0)};
        tbl[6]  = '{8'h12, 1'b0, 1'b0, ev(6'b100001, 4'h0, 8'h12, 4'h0)};
        tbl[7]  = '{8'h34, 1'b0, 1'b0, ev(6'b100001, 4'h1, 8'h34, 4'h0)};
        tbl[8]  = '{8'h02, 1'b0, 1'b0, ev(6'b001001, 4'h1, 8'h34, 4'h2)};
        tbl[9]  = '{8'h7E, 1'b0, 1'b0, ev(6'b000100, 4'h1, 8'h34, 4'h2)};
        tbl[10] = '{8'hDD, 1'b0, 1'b0, ev(6'b000001, 4'h1, 8'h34, 4'h2)};
        tbl[11] = '{8'h01, 1'b0, 1'b0, ev(6'b001001, 4'h1, 8'h34, 4'h1)};
        tbl[12] = '{8'hAA, 1'b0, 1'b0, ev(6'b000000, 4'h1, 8'h34, 4'h1)};
        tbl[13] = '{8'h03, 1'b1, 1'b0, ev(6'b000010, 4'h1, 8'h34, 4'h1)};
        tbl[14] = '{8'h55, 1'b0, 1'b1, ev(6'b000010, 4'h1, 8'h34, 4'h1)};
        tbl[15] = '{8'hBB, 1'b0, 1'b0, ev(6'b000000, 4'h1, 8'h34, 4'h1)};
        tbl[16] = '{8'h0F, 1'b0, 1'b0, ev(6'b010000, 4'hF, 8'h34, 4'h1)};

        rst = 1'b1; rx_data = 8'h00; rx_vld = 1'b0; rx_par = 1'b0; rx_stp = 1'b0;
        tick();
        tick();
        check_val("reset_state", {10'd0, act}, 32'd0);
        rst = 1'b0;
        tick();

        // Table vectors
        for (int i = 0; i < 17; i++) begin
            send(tbl[i].data, tbl[i].par, tbl[i].stp);
            check_val($sformatf("tbl%0d", i), {10'd0, snap}, {10'd0, tbl[i].exp});
        end

        // Valid held high for several cycles counts as a single byte
        rx_data = 8'h7E; rx_vld = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (cmd_err) cnt++;
        end
        rx_vld = 1'b0;
        tick();
        check_val("held_vld_one_byte", cnt, 32'd1);

        // Gap timeout after 0xAA
        rx_data = 8'hAA; rx_vld = 1'b1;
        tick();
        rx_vld = 1'b0;
        seen = -1;
        for (int k = 1; k <= TO + 20; k++) begin
            tick();
            if (frm_err && seen < 0) seen = k;
            if (seen >= 0) break;
        end
        check_val("timeout_cycle", seen, TO);
        send(8'hBB, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        check_val("after_timeout_rd", {10'd0, snap}, {10'd0, ev(6'b010000, 4'h3, 8'h34, 4'h1)});

        // Byte arriving in the very cycle the gap expires is processed
        rx_data = 8'hAA; rx_vld = 1'b1;
        tick();
        rx_vld = 1'b0;
        any_frm = 1'b0;
        for (int k = 1; k < TO; k++) begin
            tick();
            if (frm_err) any_frm = 1'b1;
        end
        rx_data = 8'h05; rx_vld = 1'b1;
        tick();
        if (frm_err) any_frm = 1'b1;
        rx_vld = 1'b0;
        tick();
        send(8'h3C, 1'b0, 1'b0);
        check_val("boundary_no_frm", any_frm, 32'd0);
        check_val("boundary_write", {10'd0, snap}, {10'd0, ev(6'b100000, 4'h5, 8'h3C, 4'h1)});

        // Reset in the middle of an ALU frame
        send(8'hCC, 1'b0, 1'b0);
        send(8'h12, 1'b0, 1'b0);
        check_val("mid_frame_clk_en", alu_clk_en, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("reset_mid_frame", {10'd0, act}, 32'd0);
        send(8'h34, 1'b0, 1'b0);
        check_val("after_reset_cmd_err", {10'd0, snap}, {10'd0, ev(6'b000100, 4'h0, 8'h00, 4'h0)});

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            r = $urandom_range(0, 9);
            case (r)
                0:       rx_data = 8'hAA;
                1:       rx_data = 8'hBB;
                2:       rx_data = 8'hCC;
                3:       rx_data = 8'hDD;
                default: rx_data = 8'($urandom_range(0, 255));
            endcase
            rx_par = ($urandom_range(0, 15) == 0);
            rx_stp = ($urandom_range(0, 15) == 0);
            rx_vld = 1'b1;
            for (int h = 0; h < $urandom_range(1, 3); h++) tick();
            rx_vld = 1'b0; rx_par = 1'b0; rx_stp = 1'b0;
            for (int g = 0; g < $urandom_range(1, 4); g++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
